// File: rtl/lc3_mem_if_if.sv
// Datapath-side bus between the LC-3 MAR/MDR/control logic and the memory interface.
interface lc3_mem_if_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              ldMAR;
   logic [ADDR_W-1:0] MAR;
   logic [DATA_W-1:0] MDR;
   logic              memWE;
   logic              memRDY;
   logic [DATA_W-1:0] mem_rdata;

   // Datapath/control side drives the strobes and MAR/MDR.
   modport master (output ldMAR, MAR, MDR, memWE, input memRDY, mem_rdata);
   // Memory interface side returns completion and read data.
   modport slave  (input ldMAR, MAR, MDR, memWE, output memRDY, mem_rdata);
endinterface

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface: sequences SRAM reads/writes with programmable wait
// states between the MAR/MDR registers and a synchronous SRAM.
// Optional build macro LC3_MMIO_EN adds the keyboard/display device registers
// (KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06) which bypass the SRAM.
module lc3_mem_if #(
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   lc3_mem_if_if.slave       bus,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_ce,
   output logic              sram_we,
   input  logic              kb_strobe,
   input  logic [7:0]        kb_data,
   input  logic              disp_ready,
   output logic              disp_strobe,
   output logic [7:0]        disp_data
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      RD_WAIT = 3'd2,
      READY   = 3'd3,
      WR_WAIT = 3'd4
   } state_t;

   state_t            state;
   logic              pending;
   logic [CNT_W-1:0]  waitCnt;
   logic              isMmio;
   logic              memRdyReg;
   logic [DATA_W-1:0] rdataReg;

   logic              mmioHit;
   logic [DATA_W-1:0] mmioRdata;
   logic              rdDone;
   logic              wrDone;

   assign bus.memRDY    = memRdyReg;
   assign bus.mem_rdata = rdataReg;

   // A new ldMAR always wins over a read that is about to complete.
   assign rdDone = (state == RD_WAIT) && !bus.ldMAR && (waitCnt == '0);
   assign wrDone = (state == WR_WAIT) && (waitCnt == '0);

`ifdef LC3_MMIO_EN
   localparam logic [ADDR_W-1:0] KBSR_ADDR = ADDR_W'(16'hFE00);
   localparam logic [ADDR_W-1:0] KBDR_ADDR = ADDR_W'(16'hFE02);
   localparam logic [ADDR_W-1:0] DSR_ADDR  = ADDR_W'(16'hFE04);
   localparam logic [ADDR_W-1:0] DDR_ADDR  = ADDR_W'(16'hFE06);

   logic       kbReady;
   logic [7:0] kbData;

   // The whole xFExx page is device space; unmapped entries read as zero.
   assign mmioHit = (bus.MAR[ADDR_W-1:8] == (ADDR_W-8)'(8'hFE));

   // Device register read mux, keyed by the latched access address.
   always_comb begin
      mmioRdata = '0;
      case (sram_addr)
         KBSR_ADDR: mmioRdata = DATA_W'({kbReady, 15'b0});
         KBDR_ADDR: mmioRdata = DATA_W'({8'h00, kbData});
         DSR_ADDR:  mmioRdata = DATA_W'({disp_ready, 15'b0});
         default:   mmioRdata = '0;
      endcase
   end

   // Keyboard status/data; a new character beats a concurrent KBDR read clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kbReady <= 1'b0;
         kbData  <= '0;
      end else if (kb_strobe) begin
         kbReady <= 1'b1;
         kbData  <= kb_data;
      end else if (rdDone && isMmio && (sram_addr == KBDR_ADDR)) begin
         kbReady <= 1'b0;
      end
   end

   // One-cycle display write pulse when a DDR write completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_strobe <= 1'b0;
         disp_data   <= '0;
      end else begin
         disp_strobe <= wrDone && isMmio && (sram_addr == DDR_ADDR);
         if (wrDone && isMmio && (sram_addr == DDR_ADDR)) begin
            disp_data <= sram_wdata[7:0];
         end
      end
   end
`else
   logic unusedMmioInputs;

   assign mmioHit          = 1'b0;
   assign mmioRdata        = '0;
   assign disp_strobe      = 1'b0;
   assign disp_data        = '0;
   assign unusedMmioInputs = ^{kb_strobe, kb_data, disp_ready};
`endif

   // Access sequencer: address launch, wait-state countdown, write phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pending    <= 1'b0;
         waitCnt    <= '0;
         isMmio     <= 1'b0;
         memRdyReg  <= 1'b0;
         rdataReg   <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_ce    <= 1'b0;
         sram_we    <= 1'b0;
      end else begin
         if (bus.ldMAR) begin
            pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (bus.ldMAR) begin
                  state <= START;
               end
            end
            START: begin
               // A repeated ldMAR keeps us here until MAR has settled.
               if (!bus.ldMAR) begin
                  pending   <= 1'b0;
                  sram_addr <= bus.MAR;
                  isMmio    <= mmioHit;
                  sram_ce   <= !mmioHit;
                  sram_we   <= 1'b0;
                  waitCnt   <= mmioHit ? '0 : WAIT_INIT;
                  state     <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (bus.ldMAR) begin
                  sram_ce <= 1'b0;
                  state   <= START;
               end else if (rdDone) begin
                  sram_ce   <= 1'b0;
                  rdataReg  <= isMmio ? mmioRdata : sram_rdata;
                  memRdyReg <= 1'b1;
                  state     <= READY;
               end else begin
                  waitCnt <= waitCnt - CNT_W'(1);
               end
            end
            READY: begin
               // A write takes priority; a same-cycle ldMAR is left pending.
               if (bus.memWE) begin
                  sram_wdata <= bus.MDR;
                  sram_ce    <= !isMmio;
                  sram_we    <= !isMmio;
                  waitCnt    <= isMmio ? '0 : WAIT_INIT;
                  memRdyReg  <= 1'b0;
                  state      <= WR_WAIT;
               end else if (bus.ldMAR) begin
                  memRdyReg <= 1'b0;
                  state     <= START;
               end
            end
            WR_WAIT: begin
               if (wrDone) begin
                  sram_ce  <= 1'b0;
                  sram_we  <= 1'b0;
                  rdataReg <= sram_wdata;
                  if (pending || bus.ldMAR) begin
                     state <= START;
                  end else begin
                     memRdyReg <= 1'b1;
                     state     <= READY;
                  end
               end else begin
                  waitCnt <= waitCnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lc3_mem_if.sv
// Self-checking bench for lc3_mem_if: SRAM model plus a latency/data reference.
module tb_lc3_mem_if;

   localparam int unsigned WS     = 2;
   localparam int          RD_LAT = WS + 2;
   localparam int          WR_LAT = WS + 1;
   localparam int          TIMEOUT = 64;

   logic        clk;
   logic        rst;
   logic [15:0] sram_addr;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata;
   logic        sram_ce;
   logic        sram_we;
   logic        kb_strobe;
   logic [7:0]  kb_data;
   logic        disp_ready;
   logic        disp_strobe;
   logic [7:0]  disp_data;

   int errors    = 0;
   int checks    = 0;
   int ceCount   = 0;
   int dispCount = 0;

   logic [15:0] sramMem [int];
   logic [15:0] refMem  [int];
   logic [15:0] curAddr;

   lc3_mem_if_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   lc3_mem_if #(.WAIT_STATES(WS), .ADDR_W(16), .DATA_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_ce    (sram_ce),
      .sram_we    (sram_we),
      .kb_strobe  (kb_strobe),
      .kb_data    (kb_data),
      .disp_ready (disp_ready),
      .disp_strobe(disp_strobe),
      .disp_data  (disp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Initial SRAM contents (x3000 holds x1234).
   function automatic logic [15:0] pattern(input logic [15:0] a);
      if (a == 16'h3000) return 16'h1234;
      return {a[7:0], a[15:8]} ^ 16'h0F0F;
   endfunction

   function automatic logic [15:0] refRead(input logic [15:0] a);
      if (refMem.exists(int'(a))) return refMem[int'(a)];
      return pattern(a);
   endfunction

   // Synchronous SRAM: data registered on the edge that samples sram_ce.
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) sramMem[int'(sram_addr)] = sram_wdata;
         else sram_rdata <= sramMem.exists(int'(sram_addr)) ? sramMem[int'(sram_addr)] : pattern(sram_addr);
      end
   end

   // Activity monitors.
   always @(posedge clk) begin
      if (sram_ce === 1'b1) ceCount++;
      if (disp_strobe === 1'b1) dispCount++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic startRead(input logic [15:0] a);
      bus.ldMAR = 1'b1;
      bus.MAR   = a;
      tick();
      bus.ldMAR = 1'b0;
      curAddr   = a;
   endtask

   task automatic waitRdy(output int n);
      n = 0;
      while (n < TIMEOUT) begin
         tick();
         n++;
         if (bus.memRDY === 1'b1) break;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++; if (bus.memRDY !== 1'b0) begin errors++; $display("FAIL reset_memRDY got=%b exp=0", bus.memRDY); end
      checks++; if (sram_ce !== 1'b0 || sram_we !== 1'b0) begin errors++; $display("FAIL reset_ce_we got=%b%b exp=00", sram_ce, sram_we); end
      checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", bus.mem_rdata); end
      checks++; if (sram_addr !== 16'h0000 || sram_wdata !== 16'h0000) begin errors++; $display("FAIL reset_addr_wdata got=%h/%h exp=0000/0000", sram_addr, sram_wdata); end
      checks++; if (disp_strobe !== 1'b0 || disp_data !== 8'h00) begin errors++; $display("FAIL reset_disp got=%b/%h exp=0/00", disp_strobe, disp_data); end
      rst = 1'b0;
      repeat (3) begin
         tick();
         checks++; if (bus.memRDY !== 1'b0 || sram_ce !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b%b exp=00", bus.memRDY, sram_ce); end
      end
   endtask

   task automatic test_ignored_we;
      bus.memWE = 1'b1;
      bus.MDR   = 16'hDEAD;
      repeat (3) begin
         tick();
         checks++; if (sram_ce !== 1'b0 || sram_we !== 1'b0 || bus.memRDY !== 1'b0) begin errors++; $display("FAIL idle_we got=%b%b%b exp=000", sram_ce, sram_we, bus.memRDY); end
      end
      bus.memWE = 1'b0;
   endtask

   task automatic test_read;
      startRead(16'h3000);
      checks++; if (sram_ce !== 1'b0 || bus.memRDY !== 1'b0) begin errors++; $display("FAIL read_k0 got=%b%b exp=00", sram_ce, bus.memRDY); end
      for (int k = 1; k <= RD_LAT; k++) begin
         tick();
         checks++; if (sram_ce !== logic'(k <= WS + 1)) begin errors++; $display("FAIL read_ce k=%0d got=%b exp=%b", k, sram_ce, k <= WS + 1); end
         checks++; if (bus.memRDY !== logic'(k == RD_LAT)) begin errors++; $display("FAIL read_rdy k=%0d got=%b exp=%b", k, bus.memRDY, k == RD_LAT); end
      end
      checks++; if (sram_addr !== 16'h3000) begin errors++; $display("FAIL read_addr got=%h exp=3000", sram_addr); end
      repeat (4) begin
         checks++; if (bus.memRDY !== 1'b1 || bus.mem_rdata !== 16'h1234) begin errors++; $display("FAIL read_hold got=%b/%h exp=1/1234", bus.memRDY, bus.mem_rdata); end
         tick();
      end
   endtask

   task automatic test_write;
      int n;
      startRead(16'h4000);
      waitRdy(n);
      checks++; if (n !== RD_LAT || bus.mem_rdata !== refRead(16'h4000)) begin errors++; $display("FAIL write_preread got=%0d/%h exp=%0d/%h", n, bus.mem_rdata, RD_LAT, refRead(16'h4000)); end
      bus.memWE = 1'b1;
      bus.MDR   = 16'hBEEF;
      tick();
      bus.memWE = 1'b0;
      for (int k = 0; k <= WR_LAT; k++) begin
         if (k > 0) tick();
         checks++; if (sram_we !== logic'(k <= WS) || sram_ce !== logic'(k <= WS) || bus.memRDY !== logic'(k == WR_LAT)) begin
            errors++; $display("FAIL write_phase k=%0d got we/ce/rdy=%b%b%b exp=%b%b%b", k, sram_we, sram_ce, bus.memRDY, k <= WS, k <= WS, k == WR_LAT);
         end
         if (k <= WS) begin
            checks++; if (sram_addr !== 16'h4000 || sram_wdata !== 16'hBEEF) begin errors++; $display("FAIL write_bus got=%h/%h exp=4000/beef", sram_addr, sram_wdata); end
         end
      end
      checks++; if (bus.mem_rdata !== 16'hBEEF) begin errors++; $display("FAIL write_raw got=%h exp=beef", bus.mem_rdata); end
      refMem[16'h4000] = 16'hBEEF;
      startRead(16'h4000);
      waitRdy(n);
      checks++; if (n !== RD_LAT || bus.mem_rdata !== 16'hBEEF) begin errors++; $display("FAIL write_readback got=%0d/%h exp=%0d/beef", n, bus.mem_rdata, RD_LAT); end
   endtask

   task automatic test_abort;
      int n;
      int d;
      logic [15:0] a1;
      for (int rep = 0; rep < 4; rep++) begin
         a1 = 16'h3000 + 16'(rep * 2);
         d  = (rep == 0) ? 1 : int'($urandom_range(0, WS + 1));
         startRead(a1);
         for (int i = 0; i < d; i++) begin
            tick();
            checks++; if (bus.memRDY !== 1'b0) begin errors++; $display("FAIL abort_early rep=%0d got=1 exp=0", rep); end
         end
         startRead(a1 + 16'h1);
         waitRdy(n);
         checks++; if (n !== RD_LAT || bus.mem_rdata !== refRead(a1 + 16'h1)) begin
            errors++; $display("FAIL abort_data rep=%0d d=%0d got=%0d/%h exp=%0d/%h", rep, d, n, bus.mem_rdata, RD_LAT, refRead(a1 + 16'h1));
         end
      end
   endtask

   task automatic test_back_to_back;
      int n;
      int weCycles;
      logic [15:0] d;
      startRead(16'h5000);
      waitRdy(n);
      d = 16'($urandom);
      bus.memWE = 1'b1;
      bus.ldMAR = 1'b1;
      bus.MDR   = d;
      bus.MAR   = 16'h5001;
      tick();
      bus.memWE = 1'b0;
      bus.ldMAR = 1'b0;
      weCycles  = (sram_we === 1'b1 && sram_addr === 16'h5000) ? 1 : 0;
      n = 0;
      while (n < TIMEOUT && bus.memRDY !== 1'b1) begin
         tick();
         n++;
         if (sram_we === 1'b1 && sram_addr === 16'h5000) weCycles++;
      end
      refMem[16'h5000] = d;
      checks++; if (n !== WR_LAT + RD_LAT) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", n, WR_LAT + RD_LAT); end
      checks++; if (weCycles !== WR_LAT) begin errors++; $display("FAIL b2b_we_cycles got=%0d exp=%0d", weCycles, WR_LAT); end
      checks++; if (bus.mem_rdata !== refRead(16'h5001)) begin errors++; $display("FAIL b2b_rdata got=%h exp=%h", bus.mem_rdata, refRead(16'h5001)); end
      curAddr = 16'h5001;
      startRead(16'h5000);
      waitRdy(n);
      checks++; if (bus.mem_rdata !== d) begin errors++; $display("FAIL b2b_readback got=%h exp=%h", bus.mem_rdata, d); end
   endtask

   task automatic test_ldmar_in_write;
      int n;
      logic [15:0] d;
      d = 16'($urandom);
      bus.memWE = 1'b1;
      bus.MDR   = d;
      tick();
      bus.memWE = 1'b0;
      tick();
      bus.ldMAR = 1'b1;
      bus.MAR   = 16'h5002;
      tick();
      bus.ldMAR = 1'b0;
      checks++; if (bus.memRDY !== 1'b0 || sram_we !== 1'b1) begin errors++; $display("FAIL pend_mid got rdy/we=%b%b exp=01", bus.memRDY, sram_we); end
      refMem[int'(curAddr)] = d;
      waitRdy(n);
      checks++; if (n + 2 !== WR_LAT + RD_LAT || bus.mem_rdata !== refRead(16'h5002)) begin
         errors++; $display("FAIL pend_read got=%0d/%h exp=%0d/%h", n + 2, bus.mem_rdata, WR_LAT + RD_LAT, refRead(16'h5002));
      end
      curAddr = 16'h5002;
   endtask

   task automatic test_rst_mid_write;
      int n;
      startRead(16'h6000);
      waitRdy(n);
      bus.memWE = 1'b1;
      bus.MDR   = 16'h1111;
      tick();
      bus.memWE = 1'b0;
      tick();
      checks++; if (sram_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre got we=%b exp=1", sram_we); end
      #2 rst = 1'b1;
      #1;
      checks++; if (sram_we !== 1'b0 || sram_ce !== 1'b0 || bus.memRDY !== 1'b0) begin errors++; $display("FAIL rstmid_async got we/ce/rdy=%b%b%b exp=000", sram_we, sram_ce, bus.memRDY); end
      #2 rst = 1'b0;
      repeat (3) begin
         tick();
         checks++; if (bus.memRDY !== 1'b0 || sram_ce !== 1'b0) begin errors++; $display("FAIL rstmid_idle got rdy/ce=%b%b exp=00", bus.memRDY, sram_ce); end
      end
      startRead(16'h3000);
      waitRdy(n);
      checks++; if (n !== RD_LAT || bus.mem_rdata !== 16'h1234) begin errors++; $display("FAIL rstmid_recover got=%0d/%h exp=%0d/1234", n, bus.mem_rdata, RD_LAT); end
   endtask

   task automatic test_random;
      int n;
      int op;
      logic [15:0] a;
      logic [15:0] d;
      startRead(16'h3100);
      waitRdy(n);
      for (int it = 0; it < 40; it++) begin
         op = int'($urandom_range(0, 2));
         a  = 16'h3100 + 16'($urandom_range(0, 15));
         d  = 16'($urandom);
         if (op == 0) begin
            startRead(a);
            waitRdy(n);
            checks++; if (n !== RD_LAT || bus.mem_rdata !== refRead(a)) begin errors++; $display("FAIL rand_read it=%0d got=%0d/%h exp=%0d/%h", it, n, bus.mem_rdata, RD_LAT, refRead(a)); end
         end else if (op == 1) begin
            bus.memWE = 1'b1;
            bus.MDR   = d;
            tick();
            bus.memWE = 1'b0;
            waitRdy(n);
            refMem[int'(curAddr)] = d;
            checks++; if (n !== WR_LAT || bus.mem_rdata !== d) begin errors++; $display("FAIL rand_write it=%0d got=%0d/%h exp=%0d/%h", it, n, bus.mem_rdata, WR_LAT, d); end
         end else begin
            bus.memWE = 1'b1;
            bus.ldMAR = 1'b1;
            bus.MDR   = d;
            bus.MAR   = a;
            tick();
            bus.memWE = 1'b0;
            bus.ldMAR = 1'b0;
            refMem[int'(curAddr)] = d;
            curAddr = a;
            waitRdy(n);
            checks++; if (n !== WR_LAT + RD_LAT || bus.mem_rdata !== refRead(a)) begin errors++; $display("FAIL rand_wr_rd it=%0d got=%0d/%h exp=%0d/%h", it, n, bus.mem_rdata, WR_LAT + RD_LAT, refRead(a)); end
         end
      end
   endtask

`ifdef LC3_MMIO_EN
   task automatic test_mmio;
      int n;
      int ce0;
      int disp0;
      ce0   = ceCount;
      disp0 = dispCount;
      kb_data   = 8'h41;
      kb_strobe = 1'b1;
      tick();
      kb_strobe = 1'b0;
      kb_data   = 8'h00;
      startRead(16'hFE00);
      waitRdy(n);
      checks++; if (n !== 2 || bus.mem_rdata !== 16'h8000) begin errors++; $display("FAIL mmio_kbsr got=%0d/%h exp=2/8000", n, bus.mem_rdata); end
      startRead(16'hFE02);
      waitRdy(n);
      checks++; if (n !== 2 || bus.mem_rdata !== 16'h0041) begin errors++; $display("FAIL mmio_kbdr got=%0d/%h exp=2/0041", n, bus.mem_rdata); end
      startRead(16'hFE00);
      waitRdy(n);
      checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("FAIL mmio_kbsr_clr got=%h exp=0000", bus.mem_rdata); end
      disp_ready = 1'b1;
      startRead(16'hFE04);
      waitRdy(n);
      checks++; if (bus.mem_rdata !== 16'h8000) begin errors++; $display("FAIL mmio_dsr got=%h exp=8000", bus.mem_rdata); end
      startRead(16'hFE06);
      waitRdy(n);
      bus.memWE = 1'b1;
      bus.MDR   = 16'h0048;
      tick();
      bus.memWE = 1'b0;
      waitRdy(n);
      checks++; if (n !== 1) begin errors++; $display("FAIL mmio_ddr_lat got=%0d exp=1", n); end
      tick();
      tick();
      checks++; if (dispCount - disp0 !== 1 || disp_data !== 8'h48) begin errors++; $display("FAIL mmio_ddr got=%0d/%h exp=1/48", dispCount - disp0, disp_data); end
      checks++; if (ceCount - ce0 !== 0) begin errors++; $display("FAIL mmio_no_ce got=%0d exp=0", ceCount - ce0); end
   endtask
`else
   task automatic test_mmio;
      int n;
      int ce0;
      int disp0;
      kb_data   = 8'h41;
      kb_strobe = 1'b1;
      disp_ready = 1'b1;
      tick();
      kb_strobe = 1'b0;
      ce0   = ceCount;
      disp0 = dispCount;
      startRead(16'hFE00);
      waitRdy(n);
      checks++; if (n !== RD_LAT || bus.mem_rdata !== refRead(16'hFE00)) begin errors++; $display("FAIL nommio_read got=%0d/%h exp=%0d/%h", n, bus.mem_rdata, RD_LAT, refRead(16'hFE00)); end
      checks++; if (ceCount - ce0 !== WS + 1) begin errors++; $display("FAIL nommio_ce got=%0d exp=%0d", ceCount - ce0, WS + 1); end
      bus.memWE = 1'b1;
      bus.MDR   = 16'h0048;
      tick();
      bus.memWE = 1'b0;
      waitRdy(n);
      refMem[16'hFE00] = 16'h0048;
      tick();
      checks++; if (dispCount - disp0 !== 0 || disp_data !== 8'h00) begin errors++; $display("FAIL nommio_disp got=%0d/%h exp=0/00", dispCount - disp0, disp_data); end
   endtask
`endif

   initial begin
      rst        = 1'b1;
      bus.ldMAR  = 1'b0;
      bus.MAR    = '0;
      bus.MDR    = '0;
      bus.memWE  = 1'b0;
      kb_strobe  = 1'b0;
      kb_data    = '0;
      disp_ready = 1'b0;
      curAddr    = '0;
      test_reset();
      test_ignored_we();
      test_read();
      test_write();
      test_abort();
      test_back_to_back();
      test_ldmar_in_write();
      test_rst_mid_write();
      test_random();
      test_mmio();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
